// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the digit scanner: scan states, slot
// indices, MSD bit layout, blank code and the captured reading format.
package digit_scan_pkg;

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_DIG  = 2'd1,
      ST_GAP  = 2'd2
   } scan_state_t;

   localparam logic [1:0] SLOT_MSD   = 2'd0;
   localparam logic [1:0] SLOT_HUND  = 2'd1;
   localparam logic [1:0] SLOT_TENS  = 2'd2;
   localparam logic [1:0] SLOT_UNITS = 2'd3;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   localparam int MSD_NTHOU = 3;
   localparam int MSD_POL   = 2;
   localparam int MSD_RANGE = 0;

   typedef struct packed {
      logic       udr;
      logic       ovr;
      logic       pol;
      logic       thou;
      logic [3:0] hund;
      logic [3:0] tens;
      logic [3:0] units;
   } reading_t;

   // MSD slot carries the half digit (inverted), polarity and range flag.
   function automatic logic [3:0] msd_code(input reading_t r);
      logic [3:0] c;
      c            = 4'b0000;
      c[MSD_NTHOU] = ~r.thou;
      c[MSD_POL]   = r.pol;
      c[MSD_RANGE] = r.ovr | r.udr;
      return c;
   endfunction

   // Counter only ever has to reach max(DWELL,GAP)-1; keep at least one bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/digit_scan_timer.sv
// Dwell/gap sequencer for the four-slot scan frame. Exposes the values its
// state will take after the coming edge so the top can register its outputs
// on the same edge as the timer itself moves.
//
//  state   | meaning
//  ST_STOP | idle, no strobe, waiting for en at a frame boundary
//  ST_DIG  | digit strobe for the current slot is high
//  ST_GAP  | blank time after the current slot's digit
module digit_scan_timer
   import digit_scan_pkg::*;
#(
   parameter int DWELL = 18,
   parameter int GAP   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output scan_state_t state_n,
   output logic [1:0]  slot_n,
   output logic        frame_start,
   output logic        frame_end
);

   localparam int             CW       = cnt_width(DWELL, GAP);
   localparam logic [CW-1:0] DWELL_TC = CW'(DWELL - 1);
   localparam logic [CW-1:0] GAP_TC   = CW'(GAP - 1);

   scan_state_t   state;
   logic [1:0]    slot;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;

   // State, slot and phase counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_STOP;
         slot  <= SLOT_MSD;
         cnt   <= '0;
      end else begin
         state <= state_n;
         slot  <= slot_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state: counter restarts at every phase change; en only matters at frame boundary.
   always_comb begin
      state_n     = state;
      slot_n      = slot;
      cnt_n       = cnt;
      frame_start = 1'b0;
      case (state)
         ST_STOP: begin
            if (en) begin
               state_n     = ST_DIG;
               slot_n      = SLOT_MSD;
               cnt_n       = '0;
               frame_start = 1'b1;
            end
         end
         ST_DIG: begin
            if (cnt == DWELL_TC) begin
               state_n = ST_GAP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_GAP: begin
            if (cnt == GAP_TC) begin
               cnt_n = '0;
               if (slot == SLOT_UNITS) begin
                  slot_n = SLOT_MSD;
                  if (en) begin
                     state_n     = ST_DIG;
                     frame_start = 1'b1;
                  end else begin
                     state_n = ST_STOP;
                  end
               end else begin
                  slot_n  = slot + 2'd1;
                  state_n = ST_DIG;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            state_n = ST_STOP;
            slot_n  = SLOT_MSD;
            cnt_n   = '0;
         end
      endcase
      frame_end = (state_n == ST_GAP) && (slot_n == SLOT_UNITS) && (cnt_n == GAP_TC);
   end

endmodule

// File: rtl/digit_scan.sv
// Multiplexed BCD digit scanner. Readings are captured into a pending
// register on du and promoted to the display shadow only at frame start,
// so a frame never mixes two readings.
module digit_scan
   import digit_scan_pkg::*;
#(
   parameter int DWELL      = 18,
   parameter int GAP        = 2,
   parameter int ZERO_BLANK = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       du,
   input  logic [3:0] d_units,
   input  logic [3:0] d_tens,
   input  logic [3:0] d_hund,
   input  logic       d_thou,
   input  logic       pol,
   input  logic       ovr,
   input  logic       udr,
   output logic [3:0] q,
   output logic [3:0] ds,
   output logic       eoc,
   output logic       bcd_err
);

   scan_state_t state_n;
   logic [1:0]  slot_n;
   logic        frame_start;
   logic        frame_end;

   reading_t    din;
   reading_t    pending;
   logic        pending_v;
   reading_t    shadow;
   reading_t    shadow_d;
   logic [3:0]  q_n;
   logic [3:0]  ds_n;
   logic        hund_blank;
   logic        tens_blank;
   logic        bad_bcd;

   digit_scan_timer #(
      .DWELL (DWELL),
      .GAP   (GAP)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .state_n     (state_n),
      .slot_n      (slot_n),
      .frame_start (frame_start),
      .frame_end   (frame_end)
   );

   assign din     = {udr, ovr, pol, d_thou, d_hund, d_tens, d_units};
   assign bad_bcd = (d_units > 4'd9) || (d_tens > 4'd9) || (d_hund > 4'd9);

   // Shadow about to be displayed: a du on the frame-start edge bypasses pending.
   always_comb begin
      shadow_d = shadow;
      if (frame_start) begin
         if (du) begin
            shadow_d = din;
         end else if (pending_v) begin
            shadow_d = pending;
         end
      end
   end

   // Digit code and strobe for the coming cycle, with optional leading-zero blanking.
   always_comb begin
      hund_blank = (ZERO_BLANK != 0) && !shadow_d.thou && (shadow_d.hund == 4'd0);
      tens_blank = hund_blank && (shadow_d.tens == 4'd0);
      q_n        = 4'd0;
      ds_n       = 4'd0;
      if (state_n == ST_DIG) begin
         ds_n = 4'b0001 << slot_n;
         case (slot_n)
            SLOT_MSD:  q_n = msd_code(shadow_d);
            SLOT_HUND: q_n = hund_blank ? BLANK_CODE : shadow_d.hund;
            SLOT_TENS: q_n = tens_blank ? BLANK_CODE : shadow_d.tens;
            default:   q_n = shadow_d.units;
         endcase
      end
   end

   // Capture registers, sticky BCD error flag and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         pending_v <= 1'b0;
         shadow    <= '0;
         bcd_err   <= 1'b0;
         q         <= 4'd0;
         ds        <= 4'd0;
         eoc       <= 1'b0;
      end else begin
         shadow <= shadow_d;
         if (frame_start) begin
            pending_v <= 1'b0;
         end else if (du) begin
            pending   <= din;
            pending_v <= 1'b1;
         end
         if (du && bad_bcd) begin
            bcd_err <= 1'b1;
         end
         q   <= q_n;
         ds  <= ds_n;
         eoc <= frame_end;
      end
   end

endmodule
